yin_diff_sweep: RTL

- Difference-function engine for the YIN pitch detector.
- On one start it computes d(tau) = sum over j=0..N-1 of (x[j] - x[j+tau])^2 for every tau in a programmable range [tau_min, tau_max], where N = 2**WINDOW_SIZE_BITS.
- Reads samples from an external dual-read-port frame buffer instead of a flat bus. Streams one result per tau over a valid/ready interface to the downstream CMND/threshold stage.

---
 rtl/yin_diff_sweep.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/yin_diff_sweep.sv
// YIN difference-function engine: sweeps tau over [tau_min, tau_max] and streams d(tau) results.
// Define YIN_MIN_TRACK_EN to track the minimum d over the sweep on min_tau/min_value.
module yin_diff_sweep #(
    parameter int DATA_WIDTH       = 16,
    parameter int WINDOW_SIZE_BITS = 8,
    parameter int MAX_TAU          = 40,
    parameter int TAU_BITS         = 6,
    parameter int ADDR_BITS        = 9,
    parameter int ACC_WIDTH        = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [TAU_BITS-1:0]   tau_min,
    input  logic [TAU_BITS-1:0]   tau_max,
    output logic [ADDR_BITS-1:0]  rd_addr_a,
    output logic [ADDR_BITS-1:0]  rd_addr_b,
    input  logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic                  done,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [TAU_BITS-1:0]   d_tau,
    output logic [ACC_WIDTH-1:0]  d_value,
    output logic [TAU_BITS-1:0]   min_tau,
    output logic [ACC_WIDTH-1:0]  min_value,
    output logic [2:0]            dbg_state
);

    // Result handshake: a result transfers on a rising edge where d_valid and d_ready are both
    // high; while d_valid is high and d_ready low, d_tau and d_value are held unchanged.

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT, S_FIN} state_t;

    localparam logic [WINDOW_SIZE_BITS-1:0] J_LAST    = '1;
    localparam logic [TAU_BITS-1:0]         MAX_TAU_T = TAU_BITS'(MAX_TAU);
    localparam int SW = ((ACC_WIDTH > 2*DATA_WIDTH) ? ACC_WIDTH : 2*DATA_WIDTH) + 1;
    localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    state_t state, state_nx;

    logic [TAU_BITS-1:0]         tau, tau_last, tau_max_clamped;
    logic [WINDOW_SIZE_BITS-1:0] j;
    logic [1:0]                  drain_cnt;
    logic                        accept, drain_done, xfer;
    logic                        v1, v2, v3;
    logic [DATA_WIDTH-1:0]       diff;
    logic [2*DATA_WIDTH-1:0]     sq;
    logic [ACC_WIDTH-1:0]        acc;
    logic [SW-1:0]               acc_sum;

    assign tau_max_clamped = (tau_max > MAX_TAU_T) ? MAX_TAU_T : tau_max;
    assign rd_addr_a = {{(ADDR_BITS-WINDOW_SIZE_BITS){1'b0}}, j};
    assign rd_addr_b = rd_addr_a + {{(ADDR_BITS-TAU_BITS){1'b0}}, tau};
    assign busy      = (state == S_RUN) || (state == S_DRAIN) || (state == S_EMIT);
    assign done      = (state == S_FIN);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        drain_done = 1'b0;
        xfer       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (tau_min > tau_max_clamped) ? S_FIN : S_RUN;
                end
            end
            S_RUN:   if (j == J_LAST) state_nx = S_DRAIN;
            S_DRAIN: begin
                // Four DRAIN edges: the last term reaches the accumulator on the third.
                if (drain_cnt == 2'd3) begin
                    drain_done = 1'b1;
                    state_nx   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (d_valid && d_ready) begin
                    xfer     = 1'b1;
                    state_nx = (tau == tau_last) ? S_FIN : S_RUN;
                end
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign acc_sum = {{(SW-ACC_WIDTH){1'b0}}, acc} + {{(SW-2*DATA_WIDTH){1'b0}}, sq};

    always_ff @(posedge clk) begin
        if (reset) begin
            tau       <= '0;
            tau_last  <= '0;
            j         <= '0;
            drain_cnt <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            diff      <= '0;
            sq        <= '0;
            acc       <= '0;
            d_valid   <= 1'b0;
            d_tau     <= '0;
            d_value   <= '0;
        end else begin
            // v1..v3 follow each issued read through read, subtract and square stages.
            v1   <= (state == S_RUN);
            v2   <= v1;
            v3   <= v2;
            diff <= (rd_data_a >= rd_data_b) ? (rd_data_a - rd_data_b) : (rd_data_b - rd_data_a);
            sq   <= {{DATA_WIDTH{1'b0}}, diff} * {{DATA_WIDTH{1'b0}}, diff};

            if (v3) acc <= (acc_sum > ACC_MAX) ? '1 : acc_sum[ACC_WIDTH-1:0];

            if (state == S_RUN)   j <= j + 1'b1;
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
            else                  drain_cnt <= '0;

            if (accept) begin
                tau      <= tau_min;
                tau_last <= tau_max_clamped;
                j        <= '0;
                acc      <= '0;
            end

            if (drain_done) begin
                d_valid <= 1'b1;
                d_tau   <= tau;
                d_value <= acc;
            end

            if (xfer) begin
                d_valid <= 1'b0;
                if (tau != tau_last) begin
                    tau <= tau + 1'b1;
                    acc <= '0;
                end
            end
        end
    end

`ifdef YIN_MIN_TRACK_EN
    logic min_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            min_tau   <= '0;
            min_value <= '0;
            min_first <= 1'b0;
        end else if (accept) begin
            min_tau   <= '0;
            min_value <= '0;
            min_first <= 1'b1;
        end else if (xfer && (min_first || (d_value < min_value))) begin
            // Strict less-than keeps the earliest tau on ties.
            min_tau   <= d_tau;
            min_value <= d_value;
            min_first <= 1'b0;
        end
    end
`else
    assign min_tau   = '0;
    assign min_value = '0;
`endif

endmodule
